// File: rtl/stimulus_hub_pkg.sv
// Shared defaults, channel naming and index-width helper for the stimulus hub.
package stimulus_hub_pkg;

  localparam int N_CH_DEF         = 6;
  localparam int DEBOUNCE_CYC_DEF = 500000;
  localparam int HOLD_CYC_DEF     = 2500000;
  localparam int FIFO_DEPTH_DEF   = 4;

  typedef enum logic [3:0] {
    CH_SALUD     = 4'd0,
    CH_HAMBRE    = 4'd1,
    CH_RESET     = 4'd2,
    CH_TEST      = 4'd3,
    CH_DIVERSION = 4'd4,
    CH_ENERGIA   = 4'd5
  } chan_e;

  // Width of a channel index; never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stimulus_hub_chan.sv
// One stimulus channel: 2-flop synchroniser, debounce, and edge or hold-time
// request generation. req is a single-cycle registered pulse.
module stimulus_hub_chan #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int HOLD_CYC     = 2500000,
  parameter bit LEVEL_MODE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic req
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC);

  logic            sync_a;
  logic            sync_b;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      db_cnt <= '0;
      level  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (sync_b == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        level  <= sync_b;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  if (LEVEL_MODE) begin : g_level
    localparam int HOLD_W = $clog2(HOLD_CYC);

    logic [HOLD_W-1:0] hold_cnt;
    logic              armed;

    // Down-counter reloads while low; fires once per high period at terminal count.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_cnt <= '0;
        armed    <= 1'b0;
        req      <= 1'b0;
      end else begin
        req <= 1'b0;
        if (!level) begin
          hold_cnt <= HOLD_W'(HOLD_CYC - 1);
          armed    <= 1'b1;
        end else if (armed) begin
          if (hold_cnt == '0) begin
            req   <= 1'b1;
            armed <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
      end
    end
  end else begin : g_edge
    logic level_prev;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        level_prev <= 1'b0;
        req        <= 1'b0;
      end else begin
        level_prev <= level;
        req        <= level & ~level_prev;
      end
    end
  end

endmodule

// File: rtl/stimulus_hub.sv
// Debounced stimulus channels feeding a per-channel pending latch, a
// lowest-index-first arbiter and a small event FIFO toward the consumer.
module stimulus_hub
  import stimulus_hub_pkg::*;
#(
  parameter int              N_CH         = N_CH_DEF,
  parameter int              DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int              HOLD_CYC     = HOLD_CYC_DEF,
  parameter logic [N_CH-1:0] LEVEL_MASK   = '0,
  parameter int              FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH-1:0]              raw_in,
  input  logic                         ev_ready,
  output logic                         ev_valid,
  output logic [idx_w(N_CH)-1:0]       ev_id,
  output logic [N_CH-1:0]              level_out,
  output logic [$clog2(FIFO_DEPTH):0]  ev_count,
  output logic                         overflow
);

  localparam int IDW = idx_w(N_CH);
  localparam int PW  = $clog2(FIFO_DEPTH);

  logic [N_CH-1:0] req;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] clr_mask;
  logic [IDW-1:0]  sel_id;
  logic [IDW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            full;
  logic            push;
  logic            pop;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    stimulus_hub_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .LEVEL_MODE   (LEVEL_MASK[i])
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_in[i]),
      .level (level_out[i]),
      .req   (req[i])
    );
  end

  always_comb begin
    sel_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending[i]) sel_id = IDW'(i);
    end
  end

  assign grant    = pending & (~pending + 1'b1);
  assign full     = (ev_count == (PW + 1)'(FIFO_DEPTH));
  assign ev_valid = (ev_count != '0);
  assign pop      = ev_valid & ev_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = (|pending) & (~full | pop);
  assign clr_mask = push ? grant : '0;
  assign ev_id    = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | req;
      // A request only collides if its bit stays set through this cycle.
      if (|(req & pending & ~clr_mask)) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   ev_count <= ev_count + 1'b1;
        2'b01:   ev_count <= ev_count - 1'b1;
        default: ev_count <= ev_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sel_id;
  end

endmodule

// File: tb/tb_stimulus_hub.sv
// Directed bench for stimulus_hub with small debounce/hold counts so every
// latency can be counted edge by edge.
module tb_stimulus_hub;
  import stimulus_hub_pkg::*;

  localparam int         N_CH  = 4;
  localparam int         DEB   = 4;
  localparam int         HOLD  = 8;
  localparam int         DEPTH = 4;
  localparam logic [3:0] LMASK = 4'b0100;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [3:0] raw_in   = '0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic [3:0] level_out;
  logic [2:0] ev_count;
  logic       overflow;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  stimulus_hub #(
    .N_CH         (N_CH),
    .DEBOUNCE_CYC (DEB),
    .HOLD_CYC     (HOLD),
    .LEVEL_MASK   (LMASK),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .ev_ready  (ev_ready),
    .ev_valid  (ev_valid),
    .ev_id     (ev_id),
    .level_out (level_out),
    .ev_count  (ev_count),
    .overflow  (overflow)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Step n edges; step s follows the (s-1)th edge after the call.
  task automatic watch(input int n, input int ch, output int ev_n,
                       output int first_step, output int first_id, output int lvl_step);
    ev_n = 0;
    first_step = 0;
    first_id = -1;
    lvl_step = 0;
    for (int s = 1; s <= n; s++) begin
      step(1);
      if (level_out[ch] && lvl_step == 0) lvl_step = s;
      if (ev_valid) begin
        if (ev_n == 0) begin
          first_step = s;
          first_id = int'(ev_id);
        end
        ev_n++;
      end
    end
  endtask

  initial begin
    int n, n2, fs, fid, ls, ls2;
    int ids[$];
    int exp_ids[5];
    exp_ids = '{0, 3, 0, 3, 1};

    #2 rst = 1'b0;
    step(2);
    check_val("rst_valid", int'(ev_valid), 0);
    check_val("rst_count", int'(ev_count), 0);
    check_val("rst_overflow", int'(overflow), 0);
    check_val("rst_level", int'(level_out), 0);
    #3;
    rst      = 1'b1;
    ev_ready = 1'b1;
    raw_in   = 4'b0010;

    // Edge channel 1: valid after edge DEB+4 counted from the sampling edge.
    watch(30, 1, n, fs, fid, ls);
    check_val("edge_first_step", fs, 9);
    check_val("edge_id", fid, 1);
    check_val("edge_n_events", n, 1);
    check_val("edge_level_step", ls, 6);

    // Falling channel 1 plus a 3-cycle glitch on channel 0: no events.
    raw_in = 4'b0001;
    watch(3, 0, n, fs, fid, ls);
    raw_in = 4'b0000;
    watch(15, 0, n2, fs, fid, ls2);
    check_val("glitch_n_events", n + n2, 0);
    check_val("glitch_level0", ls + ls2, 0);
    check_val("fall_level1", int'(level_out[1]), 0);

    // Simultaneous rise on 0 and 3 with the consumer stalled.
    ev_ready = 1'b0;
    raw_in = 4'b1001;
    step(12);
    check_val("dual_count", int'(ev_count), 2);
    check_val("dual_head", int'(ev_id), 0);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    check_val("dual_second", int'(ev_id), 3);
    check_val("dual_count_after_pop", int'(ev_count), 1);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    check_val("dual_empty", int'(ev_valid), 0);
    raw_in = 4'b0000;
    step(10);
    check_val("dual_fall_quiet", int'(ev_count), 0);

    // Level channel 2: level at step 6, request HOLD later, valid two edges on.
    ev_ready = 1'b1;
    raw_in = 4'b0100;
    watch(30, 2, n, fs, fid, ls);
    check_val("hold_level_step", ls, 6);
    check_val("hold_first_step", fs, 16);
    check_val("hold_id", fid, 2);
    check_val("hold_n_events", n, 1);
    raw_in = 4'b0000;
    step(10);
    raw_in = 4'b0100;
    watch(30, 2, n, fs, fid, ls);
    check_val("rearm_n_events", n, 1);
    check_val("rearm_id", fid, 2);
    check_val("rearm_first_step", fs, 16);
    raw_in = 4'b0000;
    step(10);

    // Fill the FIFO: ids 0,3,0,3.
    ev_ready = 1'b0;
    raw_in = 4'b1001; step(10); raw_in = 4'b0000; step(8);
    raw_in = 4'b0001; step(10); raw_in = 4'b0000; step(8);
    raw_in = 4'b1000; step(10); raw_in = 4'b0000; step(8);
    check_val("fill_count", int'(ev_count), 4);
    check_val("fill_overflow", int'(overflow), 0);
    raw_in = 4'b0010; step(10);
    check_val("pend_count", int'(ev_count), 4);
    check_val("pend_overflow", int'(overflow), 0);
    raw_in = 4'b0000; step(8);
    raw_in = 4'b0010; step(10);
    check_val("ovf_set", int'(overflow), 1);
    check_val("ovf_count", int'(ev_count), 4);
    raw_in = 4'b0000; step(8);

    // Drain; the pending id 1 enters on the first pop while full.
    ev_ready = 1'b1;
    ids.delete();
    for (int s = 0; s < 8; s++) begin
      if (ev_valid) ids.push_back(int'(ev_id));
      step(1);
      if (s == 0) check_val("full_push_pop_count", int'(ev_count), 4);
    end
    ev_ready = 1'b0;
    check_val("drain_len", ids.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < ids.size()) check_val($sformatf("drain_id%0d", k), ids[k], exp_ids[k]);
    end
    check_val("drain_ovf_sticky", int'(overflow), 1);
    check_val("drain_empty", int'(ev_valid), 0);

    // Async reset with two queued events and channel 3 mid-debounce.
    raw_in = 4'b0011;
    step(10);
    check_val("pre_rst_count", int'(ev_count), 2);
    check_val("pre_rst_ovf", int'(overflow), 1);
    raw_in = 4'b1011;
    step(3);
    #3;
    rst = 1'b0;
    raw_in = 4'b1000;
    #1;
    check_val("arst_valid", int'(ev_valid), 0);
    check_val("arst_count", int'(ev_count), 0);
    check_val("arst_overflow", int'(overflow), 0);
    check_val("arst_level", int'(level_out), 0);
    @(posedge clk);
    @(posedge clk);
    #4;
    ev_ready = 1'b1;
    rst = 1'b1;
    watch(20, 3, n, fs, fid, ls);
    check_val("post_rst_first_step", fs, 9);
    check_val("post_rst_id", fid, 3);
    check_val("post_rst_n_events", n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
